video_stream_rx: RTL and testbench

//  Synthesizable receiver for the VGA-style pixel stream (Vsync/Hsync/DataEn + 8-bit RGB) that drives
//  the image operators. Tags each pixel with X/Y coordinates and flags frame start and line end.

---
 rtl/video_stream_rx.sv | 217 +++++++++++++++++++++
 tb/tb_video_stream_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_rx.sv
// video_stream_rx: receiver for a Vsync/Hsync/DataEn + 8-bit RGB pixel stream.
// Each accepted pixel is tagged with X/Y coordinates and FrameStart/LineEnd flags.
// The receiver also measures each frame's width and height and reports sync errors.
// A pixel is held for one extra cycle in a skid stage, so that the end of its line is known
// before the pixel is presented. Pixel outputs therefore lag the inputs by 2 clocks.
module video_stream_rx #(
    parameter int W  = 48,
    parameter int H  = 36,
    parameter int XW = 12,
    parameter int YW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Vsync,
    input  logic          Hsync,
    input  logic          DataEn,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    output logic          PixValid,
    output logic [7:0]    RO,
    output logic [7:0]    GO,
    output logic [7:0]    BO,
    output logic [XW-1:0] X,
    output logic [YW-1:0] Y,
    output logic          FrameStart,
    output logic          LineEnd,
    output logic          FrameDone,
    output logic [XW-1:0] MeasW,
    output logic [YW-1:0] MeasH,
    output logic          WidthErr,
    output logic          HeightErr,
    output logic          SyncErr
);

    localparam logic [XW-1:0] W_CNT = XW'(W);
    localparam logic [YW-1:0] H_CNT = YW'(H);

    // IDLE: waiting to see Vsync low, so that a frame already in progress is never captured.
    // CLOSE: a line closed on the same edge as Vsync fell; publish the frame one cycle later.
    typedef enum logic [1:0] {IDLE, ARMED, FRAME, CLOSE} state_t;

    state_t        state, state_next;
    logic          vs_prev;
    logic          vs_rise, vs_fall;
    logic          capture, line_close;
    logic          frame_close, clear_frame;

    logic [XW-1:0] xcnt, xcnt_inc, first_w;
    logic [YW-1:0] ycnt, ycnt_inc;
    logic          x_sat, y_sat;
    logic          width_acc;

    logic          s1_valid, s1_first;
    logic [7:0]    s1_r, s1_g, s1_b;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    assign vs_rise    = Vsync & ~vs_prev;
    assign vs_fall    = ~Vsync & vs_prev;
    // Only pixels inside an armed frame with Vsync high are accepted.
    assign capture    = (state == FRAME) & Vsync & DataEn;
    // The pixel in the skid stage ends its line when no pixel follows it.
    assign line_close = s1_valid & ~capture;

    assign x_sat    = &xcnt;
    assign y_sat    = &ycnt;
    assign xcnt_inc = x_sat ? xcnt : xcnt + XW'(1);
    assign ycnt_inc = y_sat ? ycnt : ycnt + YW'(1);

    // Vsync history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_prev <= 1'b0;
        else        vs_prev <= Vsync;
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Frame sequencing: arming, frame entry and the (possibly delayed) frame close
    always_comb begin
        state_next  = state;
        frame_close = 1'b0;
        clear_frame = 1'b0;
        case (state)
            IDLE: begin
                if (!Vsync) state_next = ARMED;
            end
            ARMED: begin
                if (vs_rise) begin
                    state_next  = FRAME;
                    clear_frame = 1'b1;
                end
            end
            FRAME: begin
                if (vs_fall) begin
                    if (line_close) begin
                        state_next = CLOSE;
                    end else begin
                        state_next  = ARMED;
                        frame_close = 1'b1;
                    end
                end
            end
            CLOSE: begin
                frame_close = 1'b1;
                if (vs_rise) begin
                    state_next  = FRAME;
                    clear_frame = 1'b1;
                end else begin
                    state_next = ARMED;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Column/row counters and per-frame width bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcnt      <= '0;
            ycnt      <= '0;
            width_acc <= 1'b0;
            first_w   <= '0;
        end else if (clear_frame) begin
            xcnt      <= '0;
            ycnt      <= '0;
            width_acc <= 1'b0;
            first_w   <= '0;
        end else begin
            if (capture) xcnt <= xcnt_inc;
            if (line_close) begin
                xcnt <= '0;
                ycnt <= ycnt_inc;
                if ((xcnt != W_CNT) || x_sat) width_acc <= 1'b1;
                if (ycnt == '0) first_w <= xcnt;
            end
        end
    end

    // Frame results, published together with the FrameDone pulse and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FrameDone <= 1'b0;
            MeasW     <= '0;
            MeasH     <= '0;
            WidthErr  <= 1'b0;
            HeightErr <= 1'b0;
        end else begin
            FrameDone <= frame_close;
            if (frame_close) begin
                MeasW     <= first_w;
                MeasH     <= ycnt;
                WidthErr  <= width_acc;
                HeightErr <= (ycnt != H_CNT) || y_sat;
            end
        end
    end

    // Skid stage: holds a captured pixel until we know whether it ends its line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_first <= (xcnt == '0) && (ycnt == '0);
                s1_r     <= R;
                s1_g     <= G;
                s1_b     <= B;
                s1_x     <= xcnt;
                s1_y     <= ycnt;
            end
        end
    end

    // Output stage: pixel, coordinates and line/frame markers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PixValid   <= 1'b0;
            FrameStart <= 1'b0;
            LineEnd    <= 1'b0;
            RO         <= '0;
            GO         <= '0;
            BO         <= '0;
            X          <= '0;
            Y          <= '0;
        end else begin
            PixValid   <= s1_valid;
            FrameStart <= s1_valid & s1_first;
            LineEnd    <= line_close;
            if (s1_valid) begin
                RO <= s1_r;
                GO <= s1_g;
                BO <= s1_b;
                X  <= s1_x;
                Y  <= s1_y;
            end
        end
    end

    // Sticky sync error: pixel without Hsync, or pixel that is not part of a captured frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         SyncErr <= 1'b0;
        else if (DataEn & (~Hsync | ~capture)) SyncErr <= 1'b1;
    end

endmodule

// File: tb/tb_video_stream_rx.sv
// Testbench for video_stream_rx: builds a stimulus timeline of whole frames, derives the expected
// output timeline from frame-level rules, then replays and compares every cycle.
module tb_video_stream_rx;
    localparam int W    = 48;
    localparam int H    = 36;
    localparam int XW   = 12;
    localparam int YW   = 12;
    localparam int MAXC = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, Vsync = 1'b0, Hsync = 1'b0, DataEn = 1'b0;
    logic [7:0]    R = '0, G = '0, B = '0;
    logic          PixValid, FrameStart, LineEnd, FrameDone, WidthErr, HeightErr, SyncErr;
    logic [7:0]    RO, GO, BO;
    logic [XW-1:0] X, MeasW;
    logic [YW-1:0] Y, MeasH;

    video_stream_rx #(.W(W), .H(H), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst_n(rst_n), .Vsync(Vsync), .Hsync(Hsync), .DataEn(DataEn),
        .R(R), .G(G), .B(B),
        .PixValid(PixValid), .RO(RO), .GO(GO), .BO(BO), .X(X), .Y(Y),
        .FrameStart(FrameStart), .LineEnd(LineEnd), .FrameDone(FrameDone),
        .MeasW(MeasW), .MeasH(MeasH), .WidthErr(WidthErr), .HeightErr(HeightErr),
        .SyncErr(SyncErr)
    );

    // stimulus timeline (one entry per rising edge)
    bit          v_rst[MAXC], v_vs[MAXC], v_hs[MAXC], v_de[MAXC];
    bit [7:0]    v_r[MAXC], v_g[MAXC], v_b[MAXC];
    // expected output timeline
    bit          e_pv[MAXC], e_fs[MAXC], e_le[MAXC], e_fd[MAXC];
    bit [7:0]    e_r[MAXC], e_g[MAXC], e_b[MAXC];
    bit [XW-1:0] e_x[MAXC];
    bit [YW-1:0] e_y[MAXC];
    bit          f_evt[MAXC], f_we[MAXC], f_he[MAXC], serr_set[MAXC];
    bit [XW-1:0] f_mw[MAXC], s_mw[MAXC];
    bit [YW-1:0] f_mh[MAXC], s_mh[MAXC];
    bit          s_we[MAXC], s_he[MAXC], s_se[MAXC];

    int n = 0;
    bit armed = 0;
    int line_len[64];
    int le_idx[64];
    int last_fd, rst_rel_idx;
    int checks = 0, errors = 0;
    bit start = 0;

    int s1_begin, s1_fd, s2_le10, s2_fd, s3_fd, s3b_fd, s6_le, s6_fd;
    int p_idx, s4_next_begin, s4_fd, s5_begin, s5_fd;

    task automatic chk(input string name, input longint act, input longint exp, input int e);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, e, act, exp);
        end
    endtask

    // One input vector; the DUT arms on any non-reset edge with Vsync low.
    task automatic push(input bit rst, input bit vs, input bit hs, input bit de, input bit capt);
        if (n >= MAXC) begin
            $display("FAIL stim_overflow got=%0d expected_below=%0d", n, MAXC);
            $fatal(1);
        end
        v_rst[n] = rst; v_vs[n] = vs; v_hs[n] = hs; v_de[n] = de;
        v_r[n] = 8'($urandom); v_g[n] = 8'($urandom); v_b[n] = 8'($urandom);
        if (!rst)    armed = 0;
        else if (!vs) armed = 1;
        if (rst && de && (!hs || !capt)) serr_set[n] = 1;
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) push(1, 0, 0, 0, 0);
    endtask

    task automatic nominal_lines();
        for (int y = 0; y < 64; y++) line_len[y] = W;
    endtask

    // A frame with line lengths from line_len. Captured only if the receiver was armed.
    // simul: Vsync drops on the edge right after the last pixel.
    task automatic emit_frame(input int nl, input int vlead, input int hlead, input int gap,
                              input int tail, input bit simul, input int hsbad_line,
                              input int abort_line);
        bit capt;
        bit we;
        int idx;
        capt = armed;
        we   = 0;
        for (int i = 0; i < vlead; i++) push(1, 1, 0, 0, capt);
        for (int y = 0; y < nl; y++) begin
            for (int i = 0; i < hlead; i++) push(1, 1, 1, 0, capt);
            for (int x = 0; x < line_len[y]; x++) begin
                if (y == abort_line && x == 10) begin
                    for (int k = 0; k < 3; k++) push(0, 1, 1, 0, 0);
                    rst_rel_idx = n;
                    capt = 0;
                end
                push(1, 1, !(y == hsbad_line && x == 5), 1, capt);
                if (capt) begin
                    idx = n;  // pixel vector at n-1, visible after the following edge
                    e_pv[idx] = 1;
                    e_r[idx] = v_r[n-1]; e_g[idx] = v_g[n-1]; e_b[idx] = v_b[n-1];
                    e_x[idx] = XW'(x);
                    e_y[idx] = YW'(y);
                    e_fs[idx] = (x == 0 && y == 0);
                    e_le[idx] = (x == line_len[y] - 1);
                    if (x == line_len[y] - 1) le_idx[y] = idx;
                end
            end
            if (line_len[y] != W) we = 1;
            if (!(simul && y == nl - 1)) begin
                push(1, 1, 1, 0, capt);
                if (y < nl - 1)
                    for (int i = 0; i < gap - 1 - hlead; i++) push(1, 1, 0, 0, capt);
            end
        end
        if (!simul) for (int i = 0; i < tail; i++) push(1, 1, 0, 0, capt);
        idx = simul ? n + 1 : n;
        if (capt) begin
            f_evt[idx] = 1;
            f_mw[idx]  = XW'(line_len[0]);
            f_mh[idx]  = YW'(nl);
            f_we[idx]  = we;
            f_he[idx]  = (nl != H);
            last_fd    = idx;
        end else begin
            last_fd = -1;
        end
    endtask

    task automatic build();
        bit [XW-1:0] mw;
        bit [YW-1:0] mh;
        bit we, he, se;
        for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 0);
        idle(5);
        // nominal frame
        nominal_lines();
        s1_begin = n;
        emit_frame(36, 6, 5, 152, 7, 0, -1, -1);
        s1_fd = last_fd;
        idle(8);
        // short line 10
        line_len[10] = 47;
        emit_frame(36, 3, 2, 8, 4, 0, -1, -1);
        s2_le10 = le_idx[10];
        s2_fd = last_fd;
        idle(6);
        // 35-line frame, then a nominal one
        nominal_lines();
        emit_frame(35, 3, 2, 8, 4, 0, -1, -1);
        s3_fd = last_fd;
        idle(6);
        emit_frame(36, 2, 3, 6, 3, 0, -1, -1);
        s3b_fd = last_fd;
        idle(5);
        // Vsync falls together with the end of the last line
        emit_frame(36, 2, 2, 6, 3, 1, -1, -1);
        s6_le = le_idx[35];
        s6_fd = last_fd;
        idle(6);
        // pixel pulse outside any frame
        p_idx = n;
        push(1, 0, 1, 1, 0);
        push(1, 0, 1, 1, 0);
        idle(6);
        // reset at line 20, released while Vsync stays high
        emit_frame(36, 2, 2, 6, 3, 0, -1, 20);
        idle(5);
        s4_next_begin = n;
        emit_frame(36, 2, 2, 6, 3, 0, -1, -1);
        s4_fd = last_fd;
        idle(4);
        // reset between frames, then a frame with one pixel lacking Hsync
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        idle(5);
        s5_begin = n;
        emit_frame(36, 2, 2, 6, 3, 0, 3, -1);
        s5_fd = last_fd;
        idle(5);
        // randomized frames
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(38, 33);
            for (int y = 0; y < 64; y++)
                line_len[y] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(50, 46)) : W;
            emit_frame(nl, $urandom_range(6, 1), $urandom_range(4, 1), $urandom_range(12, 3),
                       $urandom_range(5, 1), bit'($urandom_range(1, 0)), -1, -1);
            idle($urandom_range(8, 3));
        end
        // resolve status outputs over time: reset clears everything, frame results hold
        mw = '0; mh = '0; we = 0; he = 0; se = 0;
        for (int e = 0; e < n; e++) begin
            if (!v_rst[e]) begin
                mw = '0; mh = '0; we = 0; he = 0; se = 0;
                e_pv[e] = 0; e_fs[e] = 0; e_le[e] = 0; e_fd[e] = 0;
            end else begin
                if (f_evt[e]) begin
                    e_fd[e] = 1;
                    mw = f_mw[e]; mh = f_mh[e]; we = f_we[e]; he = f_he[e];
                end
                if (serr_set[e]) se = 1;
            end
            s_mw[e] = mw; s_mh[e] = mh; s_we[e] = we; s_he[e] = he; s_se[e] = se;
        end
    endtask

    // driver: applies vector e before rising edge e
    initial begin : driver
        build();
        @(negedge clk);
        for (int e = 0; e < n; e++) begin
            rst_n = v_rst[e]; Vsync = v_vs[e]; Hsync = v_hs[e]; DataEn = v_de[e];
            R = v_r[e]; G = v_g[e]; B = v_b[e];
            if (e == 0) start = 1;
            if (e > 0 && !v_rst[e] && v_rst[e-1]) begin
                #1;
                chk("async_reset_outputs",
                    longint'(|{PixValid, RO, GO, BO, X, Y, FrameStart, LineEnd, FrameDone,
                               MeasW, MeasH, WidthErr, HeightErr, SyncErr}), 0, e);
            end
            @(negedge clk);
        end
    end

    // compare: checks every edge against the expected timeline, plus pinned literals
    initial begin : compare
        int c_pv, c_le47, c_fs00, w_pv, w_fd, p_pv;
        c_pv = 0; c_le47 = 0; c_fs00 = 0; w_pv = 0; w_fd = 0; p_pv = 0;
        wait (start);
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            chk("PixValid", PixValid, e_pv[e], e);
            if (e_pv[e]) begin
                chk("RO", RO, e_r[e], e);
                chk("GO", GO, e_g[e], e);
                chk("BO", BO, e_b[e], e);
                chk("X", X, e_x[e], e);
                chk("Y", Y, e_y[e], e);
            end
            chk("FrameStart", FrameStart, e_fs[e], e);
            chk("LineEnd", LineEnd, e_le[e], e);
            chk("FrameDone", FrameDone, e_fd[e], e);
            chk("MeasW", MeasW, s_mw[e], e);
            chk("MeasH", MeasH, s_mh[e], e);
            chk("WidthErr", WidthErr, s_we[e], e);
            chk("HeightErr", HeightErr, s_he[e], e);
            chk("SyncErr", SyncErr, s_se[e], e);

            if (e == 1) chk("reset_state_pv_meas", longint'(|{PixValid, MeasW, MeasH, SyncErr}), 0, e);
            if (e >= s1_begin && e <= s1_fd) begin
                c_pv   += int'(PixValid);
                c_le47 += int'(LineEnd && X == 47);
                c_fs00 += int'(FrameStart && X == 0 && Y == 0);
            end
            if (e == s1_fd) begin
                chk("s1_pixel_count", c_pv, 1728, e);
                chk("s1_lineend_x47_count", c_le47, 36, e);
                chk("s1_framestart_count", c_fs00, 1, e);
                chk("s1_framedone", FrameDone, 1, e);
                chk("s1_measw", MeasW, 48, e);
                chk("s1_meash", MeasH, 36, e);
                chk("s1_errs", longint'({WidthErr, HeightErr, SyncErr}), 0, e);
            end
            if (e == s2_le10) begin
                chk("s2_le10_flag", LineEnd, 1, e);
                chk("s2_le10_x", X, 46, e);
                chk("s2_le10_y", Y, 10, e);
            end
            if (e == s2_fd) begin
                chk("s2_widtherr", WidthErr, 1, e);
                chk("s2_heighterr", HeightErr, 0, e);
                chk("s2_measw", MeasW, 48, e);
            end
            if (e == s3_fd) begin
                chk("s3_meash", MeasH, 35, e);
                chk("s3_heighterr", HeightErr, 1, e);
            end
            if (e == s3b_fd) chk("s3b_errs_cleared", longint'({WidthErr, HeightErr}), 0, e);
            if (e == s6_le) begin
                chk("s6_lineend", LineEnd, 1, e);
                chk("s6_lineend_y", Y, 35, e);
                chk("s6_no_early_done", FrameDone, 0, e);
            end
            if (e == s6_le + 1) begin
                chk("s6_framedone_late", FrameDone, 1, e);
                chk("s6_meash", MeasH, 36, e);
            end
            if (e == p_idx - 1) chk("s5_syncerr_before", SyncErr, 0, e);
            if (e >= p_idx && e <= p_idx + 3) p_pv += int'(PixValid);
            if (e == p_idx) chk("s5_syncerr_set", SyncErr, 1, e);
            if (e == p_idx + 3) chk("s5_no_pixel_out_of_frame", p_pv, 0, e);
            if (e >= rst_rel_idx && e < s4_next_begin) begin
                w_pv += int'(PixValid);
                w_fd += int'(FrameDone);
            end
            if (e == s4_next_begin) begin
                chk("s4_no_pixels_after_midframe_release", w_pv, 0, e);
                chk("s4_no_framedone_abandoned", w_fd, 0, e);
            end
            if (e == s4_fd) begin
                chk("s4_next_framedone", FrameDone, 1, e);
                chk("s4_next_meash", MeasH, 36, e);
            end
            if (e == s5_begin - 1) chk("s5b_syncerr_cleared", SyncErr, 0, e);
            if (e == s5_fd) chk("s5b_syncerr_hsync", SyncErr, 1, e);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
